// File: rtl/pe_requant_out_if.sv
// Result stream interface for pe_requant_out.
// The master drives out_valid/out_data and the slave drives out_ready.
// A word transfers on a rising clock edge where out_valid and out_ready are both high.
interface pe_requant_out_if #(
    parameter int OUT_W = 8
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/pe_requant_out.sv
// pe_requant_out: downstream collector for pe_unit.
// It counts the MAC-issue pulses sent to the PE. After k_len MACs it samples the
// PE accumulator and forms the window sum as (acc - previous sample), because the
// PE has no clear. The sum is rounded, shifted and saturated to int8, then queued
// in a small FIFO that is drained over valid/ready.
//
// Optional feature: define REQUANT_RELU_EN to force negative results to zero
// before saturation. The output range is then 0..127.
//
// Capture timing: the MAC that closes a window enters a PE_LAT-deep token line.
// The accumulator is sampled when that token reaches the end of the line, which is
// exactly when acc_in reflects the closing MAC. A MAC pulse that arrives while a
// capture is still pending starts the next window straight away, so the capture is
// never stalled.
module pe_requant_out #(
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 8,
    parameter int PE_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mac_fire,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic        [7:0]       k_len,
    input  logic        [4:0]       shift,
    pe_requant_out_if.master        out_if,
    output logic                    busy,
    output logic                    ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [OUT_W-1:0] Q_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] Q_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic {
        S_IDLE,
        S_ACC
    } state_e;

    // Window counting
    state_e            r_state;
    state_e            w_state_nxt;
    logic [7:0]        r_count;
    logic [7:0]        r_k;
    logic [4:0]        r_shift;
    logic              w_start;
    logic [7:0]        w_k_eff;
    logic [7:0]        w_win_k;
    logic [4:0]        w_win_shift;
    logic [7:0]        w_cnt_inc;
    logic              w_done;

    // Capture token line and requant stage
    logic [PE_LAT-1:0] r_tok_v;
    logic [4:0]        r_tok_shift [PE_LAT];
    logic              w_cap;
    logic [4:0]        w_cap_shift;
    logic signed [ACC_W-1:0] r_acc_base;
    logic signed [ACC_W-1:0] w_delta;
    logic              r_st_v;
    logic signed [ACC_W-1:0] r_st_delta;
    logic [4:0]        r_st_shift;
    logic signed [ACC_W:0]   w_ext;
    logic signed [ACC_W:0]   w_rnd;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W:0]   w_r;
    logic signed [OUT_W-1:0] w_q;

    // Result FIFO
    logic signed [OUT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_fcnt;
    logic signed [OUT_W-1:0] r_head;
    logic signed [OUT_W-1:0] w_head_nxt;
    logic              r_ovf;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_wr_en;
    logic              w_drop;

    // Decode the MAC pulse against the current window: start a new one or extend it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        w_k_eff     = (k_len == 8'd0) ? 8'd1 : k_len;
        w_start     = (r_state == S_IDLE);
        w_win_k     = w_start ? w_k_eff : r_k;
        w_win_shift = w_start ? shift : r_shift;
        w_cnt_inc   = w_start ? 8'd1 : r_count + 8'd1;
        w_done      = mac_fire && (w_cnt_inc == w_win_k);
    end

    // Next-state logic for the window FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (mac_fire && !w_done) w_state_nxt = S_ACC;
            S_ACC:   if (w_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register for the window FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // MAC count and the k_len/shift latched at the start of the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_k     <= '0;
            r_shift <= '0;
        end else if (mac_fire) begin
            r_count <= w_done ? 8'd0 : w_cnt_inc;
            if (w_start) begin
                r_k     <= w_k_eff;
                r_shift <= shift;
            end
        end
    end

    // Delay the closing MAC by PE_LAT cycles so capture lines up with acc_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tok_v <= '0;
            for (int i = 0; i < PE_LAT; i++) r_tok_shift[i] <= '0;
        end else begin
            r_tok_v[0]     <= w_done;
            r_tok_shift[0] <= w_win_shift;
            for (int i = 1; i < PE_LAT; i++) begin
                r_tok_v[i]     <= r_tok_v[i-1];
                r_tok_shift[i] <= r_tok_shift[i-1];
            end
        end
    end

    assign w_cap       = r_tok_v[PE_LAT-1];
    assign w_cap_shift = r_tok_shift[PE_LAT-1];
    assign w_delta     = acc_in - r_acc_base;

    // Capture: register the window delta and move the base to the current accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_base <= '0;
            r_st_v     <= 1'b0;
            r_st_delta <= '0;
            r_st_shift <= '0;
        end else begin
            r_st_v <= w_cap;
            if (w_cap) begin
                r_acc_base <= acc_in;
                r_st_delta <= w_delta;
                r_st_shift <= w_cap_shift;
            end
        end
    end

    // Requantise the staged delta: round half up, arithmetic shift, then saturate.
    always_comb begin
        w_ext = $signed({r_st_delta[ACC_W-1], r_st_delta});
        w_rnd = (ACC_W+1)'(1) << (r_st_shift - 5'd1);
        w_sum = w_ext + w_rnd;
        w_r   = (r_st_shift == 5'd0) ? w_ext : (w_sum >>> r_st_shift);
`ifdef REQUANT_RELU_EN
        if (w_r[ACC_W]) w_r = '0;
`endif
        if (w_r > SAT_MAX)      w_q = Q_MAX;
        else if (w_r < SAT_MIN) w_q = Q_MIN;
        else                    w_q = w_r[OUT_W-1:0];
    end

    // FIFO handshake decode. A full FIFO still accepts a push when it pops in the same cycle.
    always_comb begin
        w_push  = r_st_v;
        w_pop   = (r_fcnt != '0) && out_if.out_ready;
        w_full  = (r_fcnt == (PTR_W+1)'(FIFO_DEPTH));
        w_wr_en = w_push && (!w_full || w_pop);
        w_drop  = w_push && w_full && !w_pop;
        w_head_nxt = r_head;
        if (w_pop) begin
            if (r_fcnt > (PTR_W+1)'(1)) w_head_nxt = r_mem[r_rd_ptr + PTR_W'(1)];
            else if (w_wr_en)           w_head_nxt = w_q;
        end else if ((r_fcnt == '0) && w_wr_en) begin
            w_head_nxt = w_q;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; the pointers and occupancy decide which entries are valid.
        if (w_wr_en) r_mem[r_wr_ptr] <= w_q;
    end

    // FIFO pointers, occupancy, registered head and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcnt   <= '0;
            r_head   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_fcnt <= r_fcnt + (PTR_W+1)'(w_wr_en) - (PTR_W+1)'(w_pop);
            r_head <= w_head_nxt;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign out_if.out_valid = (r_fcnt != '0);
    assign out_if.out_data  = r_head;
    assign busy             = (r_state == S_ACC) || (|r_tok_v);
    assign ovf              = r_ovf;

endmodule
